// File: rtl/ram_byte_port.sv
// Byte-addressable CPU port onto a 32-bit single-port block RAM.
// Sub-word stores are done as read-modify-write; loads extract and extend a lane.
module ram_byte_port #(
  parameter int unsigned WORDS = 3584
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [16:0] cpu_addr,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_signed,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_err,
  output logic        cpu_busy,
  output logic [14:0] ram_addr,
  output logic [31:0] ram_din,
  output logic        ram_we,
  input  logic [31:0] ram_out
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  lane_q, lane_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [14:0] raddr_q, raddr_d;
  logic [31:0] rdin_q, rdin_d;
  logic        rwe_q, rwe_d;

  logic        req_err;
  logic [31:0] shifted;
  logic [31:0] load_val;
  logic [31:0] lane_mask;
  logic [31:0] merged;

  assign req_err = (cpu_size == 2'b11)
                 | ((cpu_size == 2'b01) & cpu_addr[0])
                 | ((cpu_size == 2'b10) & (|cpu_addr[1:0]))
                 | (32'(cpu_addr[16:2]) >= WORDS);

  assign shifted   = ram_out >> {lane_q, 3'b000};
  assign lane_mask = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << {lane_q, 3'b000};
  assign merged    = (ram_out & ~lane_mask) | ((wdata_q << {lane_q, 3'b000}) & lane_mask);

  always_comb begin
    case (size_q)
      2'b00:   load_val = sgn_q ? {{24{shifted[7]}}, shifted[7:0]} : {24'h0, shifted[7:0]};
      2'b01:   load_val = sgn_q ? {{16{shifted[15]}}, shifted[15:0]} : {16'h0, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  // ack/err are registered, so the completion cycle is already IDLE and can accept
  // the next request; DONE is never entered in normal operation and only recovers.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    lane_d  = lane_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    raddr_d = raddr_q;
    rdin_d  = rdin_q;
    rwe_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          we_d    = cpu_we;
          lane_d  = cpu_addr[1:0];
          size_d  = cpu_size;
          sgn_d   = cpu_signed;
          wdata_d = cpu_wdata;
          if (req_err) begin
            ack_d = 1'b1;
            err_d = 1'b1;
          end else begin
            raddr_d = cpu_addr[16:2];
            if (cpu_we && cpu_size == 2'b10) begin
              rdin_d  = cpu_wdata;
              rwe_d   = 1'b1;
              state_d = WR;
            end else begin
              state_d = RD;
            end
          end
        end
      end
      RD: state_d = CAP;
      CAP: begin
        if (we_q) begin
          rdin_d  = merged;
          rwe_d   = 1'b1;
          state_d = WR;
        end else begin
          rdata_d = load_val;
          ack_d   = 1'b1;
          state_d = IDLE;
        end
      end
      WR: begin
        ack_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      lane_q  <= '0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      raddr_q <= '0;
      rdin_q  <= '0;
      rwe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      raddr_q <= raddr_d;
      rdin_q  <= rdin_d;
      rwe_q   <= rwe_d;
    end
  end

  assign cpu_rdata = rdata_q;
  assign cpu_ack   = ack_q;
  assign cpu_err   = err_q;
  assign cpu_busy  = (state_q != IDLE);
  assign ram_addr  = raddr_q;
  assign ram_din   = rdin_q;
  assign ram_we    = rwe_q;

endmodule
